display_arbiter: RTL and testbench
==================================

# display_arbiter

Arbitrates between the two producers of display content and sequences frames into the `output_driver` valid/ready port. The producers are the ALU result path and the operand-entry echo path. The block holds the last accepted frame and re-sends it periodically so the external 7-segment shift-register chain recovers from glitches. It sits between the calculator core and `output_driver`.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of displayed magnitude.
- `REFRESH_CYCLES`, 1000000, idle cycles before the stored frame is re-sent. Value 0 disables refresh. The counter width is `$clog2(REFRESH_CYCLES+1)`.

Ports:
- `clk`  in  1  sole clock, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_res_data`  in  DATA_WIDTH  result magnitude (absolute value).
- `i_res_error`  in  1  result is an error frame.
- `i_res_neg`  in  1  result is negative.
- `i_res_valid`  in  1  result request.
- `o_res_ready`  out  1  result accepted when high with `i_res_valid`.
- `i_ech_data`  in  DATA_WIDTH  operand-echo magnitude.
- `i_ech_neg`  in  1  operand-echo negative.
- `i_ech_valid`  in  1  echo request.
- `o_ech_ready`  out  1  echo accepted when high with `i_ech_valid`.
- `o_data`  out  DATA_WIDTH  to `output_driver` `i_data`.
- `o_error`  out  1  to `output_driver` `i_error`.
- `o_data_is_neg`  out  1  to `output_driver` `i_data_is_neg`.
- `o_valid`  out  1  to `output_driver` `i_valid`.
- `i_ready`  in  1  from `output_driver` `o_ready`.

## Operation
- Storage: frame registers `{data, error, neg}`, flag `have_frame`, refresh counter `rcnt`.
- There are two states, IDLE and SEND. `o_valid` = (state == SEND).
- Ready outputs are combinational from state and request:
  - `o_res_ready` = (state == IDLE).
  - `o_ech_ready` = (state == IDLE) && !`i_res_valid`.
- Priority is fixed: result beats echo. Each accepted request beats refresh.
- IDLE, with `i_res_valid`:
  - Capture `{i_res_data, i_res_error, i_res_neg}`.
  - Set `have_frame`, clear `rcnt`, go to SEND.
- IDLE, else with `i_ech_valid`:
  - Capture `{i_ech_data, 0, i_ech_neg}`. The echo never carries error.
  - Set `have_frame`, clear `rcnt`, go to SEND.
- IDLE, else with `have_frame` and REFRESH_CYCLES≠0:
  - Increment `rcnt`.
  - When `rcnt` == REFRESH_CYCLES-1, clear `rcnt` and go to SEND with the stored frame unchanged.
- IDLE, else: hold. `rcnt` stays 0 while `!have_frame`.
- SEND:
  - `o_data`, `o_error` and `o_data_is_neg` are driven directly from the frame registers and stay stable.
  - No request is accepted (both readies are 0).
  - On `i_ready`, go to IDLE and clear `rcnt`.
- A request arriving in the same cycle the refresh would fire wins: its frame is captured and `rcnt` is cleared.

## Timing
- Reset (async assert, sync-safe deassert by the top level):
  - state IDLE.
  - `o_valid` 0, `o_data` 0, `o_error` 0, `o_data_is_neg` 0.
  - `have_frame` 0, `rcnt` 0.
  - After reset `o_res_ready` = 1 and `o_ech_ready` = !`i_res_valid`.
- Latency: a request accepted at edge N gives `o_valid` = 1 with the new frame from cycle N+1.
- Throughput: a completed transfer at edge M gives readies = 1 from cycle M+1. The minimum frame period is 2 cycles when `i_ready` is held high.
- `o_valid`, once raised, stays high with stable outputs until `i_ready` is sampled high. This holds regardless of pending requests.
- Refresh timing: with no requests after a transfer completes at edge M, the refresh `o_valid` rises at cycle M+REFRESH_CYCLES+1.
- Reset during SEND drops the frame. `o_valid` falls immediately (asynchronously) and no refresh occurs until a new frame is accepted.

## Test plan
- **Reset:** assert `rst_n`=0 mid-SEND -> `o_valid`=0 and `o_data`=0 immediately. After release, 3·REFRESH_CYCLES idle cycles produce no `o_valid`.
- **Simultaneous requests:** `i_res_valid` with data 0x1234, `i_res_neg`=1, together with `i_ech_valid` with data 0x0042, both in the same IDLE cycle -> result accepted, `o_ech_ready`=0. Next cycle `o_data`=0x1234 and `o_data_is_neg`=1. Once `i_ready` completes it, echo 0x0042 is accepted with `o_error`=0.
- **Backpressure:** hold `i_ready`=0 for 20 cycles during SEND with new requests pending -> outputs stable, both readies 0. Release -> exactly one transfer, readies 1 on the next cycle.
- **Refresh (REFRESH_CYCLES=8):** after the 0x00FF transfer completes at edge M, with no requests -> `o_valid` rises at cycle M+9 with `o_data`=0x00FF. This repeats every 8+handshake cycles.
- **Refresh collision (REFRESH_CYCLES=8):** `i_ech_valid` with 0x0007 in the exact cycle refresh would fire -> echo frame 0x0007 is sent, not the old frame. The next refresh occurs 8 idle cycles later.
- **Error frame:** `i_res_error`=1 with data 0 -> `o_error`=1. The following echo request with `i_ech_neg`=1 -> `o_error`=0 and `o_data_is_neg`=1.

Source files
------------

// File: rtl/display_arbiter.sv
// Display content arbiter: result path beats operand echo, with periodic
// re-send of the last accepted frame to keep the 7-segment chain in sync.
module display_arbiter #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned REFRESH_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_res_data,
    input  logic                  i_res_error,
    input  logic                  i_res_neg,
    input  logic                  i_res_valid,
    output logic                  o_res_ready,
    input  logic [DATA_WIDTH-1:0] i_ech_data,
    input  logic                  i_ech_neg,
    input  logic                  i_ech_valid,
    output logic                  o_ech_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_error,
    output logic                  o_data_is_neg,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam int unsigned CW_RAW = $clog2(REFRESH_CYCLES + 1);
    localparam int unsigned CW     = (CW_RAW == 0) ? 1 : CW_RAW;
    localparam int unsigned RLAST  = (REFRESH_CYCLES == 0) ? 0
                                   : REFRESH_CYCLES - 1;
    localparam logic [CW-1:0] RCNT_LAST  = CW'(RLAST);
    localparam bit            REFRESH_EN = (REFRESH_CYCLES != 0);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  error_q, error_d;
    logic                  neg_q, neg_d;
    logic                  have_q, have_d;
    logic [CW-1:0]         rcnt_q, rcnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            error_q <= 1'b0;
            neg_q   <= 1'b0;
            have_q  <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            data_q  <= data_d;
            error_q <= error_d;
            neg_q   <= neg_d;
            have_q  <= have_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Accepted requests always pre-empt a refresh that would fire this cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        error_d = error_q;
        neg_d   = neg_q;
        have_d  = have_q;
        rcnt_d  = rcnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_res_valid) begin
                    data_d  = i_res_data;
                    error_d = i_res_error;
                    neg_d   = i_res_neg;
                    have_d  = 1'b1;
                    rcnt_d  = '0;
                    state_d = SEND;
                end else if (i_ech_valid) begin
                    data_d  = i_ech_data;
                    error_d = 1'b0;
                    neg_d   = i_ech_neg;
                    have_d  = 1'b1;
                    rcnt_d  = '0;
                    state_d = SEND;
                end else if (have_q && REFRESH_EN) begin
                    if (rcnt_q == RCNT_LAST) begin
                        rcnt_d  = '0;
                        state_d = SEND;
                    end else begin
                        rcnt_d = rcnt_q + CW'(1);
                    end
                end
            end
            SEND: begin
                if (i_ready) begin
                    rcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_valid     = (state_q == SEND);
        o_res_ready = (state_q == IDLE);
        o_ech_ready = (state_q == IDLE) && !i_res_valid;
    end

    assign o_data        = data_q;
    assign o_error       = error_q;
    assign o_data_is_neg = neg_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with a short refresh period.
module tb_display_arbiter;

    localparam int DW = 16;
    localparam int RC = 8;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] i_res_data;
    logic          i_res_error;
    logic          i_res_neg;
    logic          i_res_valid;
    logic          o_res_ready;
    logic [DW-1:0] i_ech_data;
    logic          i_ech_neg;
    logic          i_ech_valid;
    logic          o_ech_ready;
    logic [DW-1:0] o_data;
    logic          o_error;
    logic          o_data_is_neg;
    logic          o_valid;
    logic          i_ready;

    int total = 0;
    int bad   = 0;

    display_arbiter #(
        .DATA_WIDTH    (DW),
        .REFRESH_CYCLES(RC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_res_data   (i_res_data),
        .i_res_error  (i_res_error),
        .i_res_neg    (i_res_neg),
        .i_res_valid  (i_res_valid),
        .o_res_ready  (o_res_ready),
        .i_ech_data   (i_ech_data),
        .i_ech_neg    (i_ech_neg),
        .i_ech_valid  (i_ech_valid),
        .o_ech_ready  (o_ech_ready),
        .o_data       (o_data),
        .o_error      (o_error),
        .o_data_is_neg(o_data_is_neg),
        .o_valid      (o_valid),
        .i_ready      (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // {o_valid, o_error, o_data_is_neg, o_data}
    function automatic logic [31:0] frame();
        return {13'd0, o_valid, o_error, o_data_is_neg, o_data};
    endfunction

    function automatic logic [31:0] fexp(input logic v, input logic e,
                                         input logic n,
                                         input logic [DW-1:0] d);
        return {13'd0, v, e, n, d};
    endfunction

    initial begin
        rst_n       = 1'b0;
        i_res_data  = '0;
        i_res_error = 1'b0;
        i_res_neg   = 1'b0;
        i_res_valid = 1'b0;
        i_ech_data  = '0;
        i_ech_neg   = 1'b0;
        i_ech_valid = 1'b0;
        i_ready     = 1'b0;

        cyc();
        cyc();
        chk("rst_frame", frame(), fexp(0, 0, 0, 16'h0000));
        chk("rst_rdy", {30'd0, o_res_ready, o_ech_ready}, 32'h3);
        i_res_valid = 1'b1;
        #1;
        chk("rst_ech_rdy_masked", {31'd0, o_ech_ready}, 32'h0);
        i_res_valid = 1'b0;
        rst_n = 1'b1;
        cyc();

        // simultaneous result and echo: result wins
        i_res_valid = 1'b1;
        i_res_data  = 16'h1234;
        i_res_neg   = 1'b1;
        i_ech_valid = 1'b1;
        i_ech_data  = 16'h0042;
        i_ech_neg   = 1'b0;
        #1;
        chk("sim_rdy", {30'd0, o_res_ready, o_ech_ready}, 32'h2);
        cyc();
        i_res_valid = 1'b0;
        i_res_neg   = 1'b0;
        #1;
        chk("sim_frame", frame(), fexp(1, 0, 1, 16'h1234));

        // backpressure with an echo pending
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("bp_frame", frame(), fexp(1, 0, 1, 16'h1234));
            chk("bp_rdy", {30'd0, o_res_ready, o_ech_ready}, 32'h0);
        end
        i_ready = 1'b1;
        cyc();
        i_ready = 1'b0;
        chk("bp_release_valid", {31'd0, o_valid}, 32'h0);
        chk("bp_release_rdy", {30'd0, o_res_ready, o_ech_ready}, 32'h3);
        cyc();
        i_ech_valid = 1'b0;
        chk("ech_frame", frame(), fexp(1, 0, 0, 16'h0042));
        i_ready = 1'b1;
        cyc();
        i_ready = 1'b0;
        chk("ech_done", {31'd0, o_valid}, 32'h0);

        // error frame then negative echo
        i_res_valid = 1'b1;
        i_res_data  = 16'h0000;
        i_res_error = 1'b1;
        cyc();
        i_res_valid = 1'b0;
        i_res_error = 1'b0;
        chk("err_frame", frame(), fexp(1, 1, 0, 16'h0000));
        i_ready = 1'b1;
        cyc();
        i_ready = 1'b0;
        i_ech_valid = 1'b1;
        i_ech_data  = 16'h0010;
        i_ech_neg   = 1'b1;
        cyc();
        i_ech_valid = 1'b0;
        i_ech_neg   = 1'b0;
        chk("neg_ech_frame", frame(), fexp(1, 0, 1, 16'h0010));
        i_ready = 1'b1;
        cyc();
        i_ready = 1'b0;

        // refresh of 0x00FF, twice
        i_res_valid = 1'b1;
        i_res_data  = 16'h00FF;
        cyc();
        i_res_valid = 1'b0;
        chk("ff_frame", frame(), fexp(1, 0, 0, 16'h00FF));
        for (int r = 0; r < 2; r++) begin
            i_ready = 1'b1;
            cyc();
            i_ready = 1'b0;
            for (int k = 1; k < RC; k++) begin
                cyc();
                chk("rf_quiet", {31'd0, o_valid}, 32'h0);
            end
            cyc();
            chk("rf_fire", frame(), fexp(1, 0, 0, 16'h00FF));
        end

        // echo lands in the cycle the refresh would fire
        i_ready = 1'b1;
        cyc();
        i_ready = 1'b0;
        for (int k = 1; k < RC; k++) begin
            cyc();
            chk("col_quiet", {31'd0, o_valid}, 32'h0);
        end
        i_ech_valid = 1'b1;
        i_ech_data  = 16'h0007;
        #1;
        chk("col_rdy", {31'd0, o_ech_ready}, 32'h1);
        cyc();
        i_ech_valid = 1'b0;
        chk("col_frame", frame(), fexp(1, 0, 0, 16'h0007));
        i_ready = 1'b1;
        cyc();
        i_ready = 1'b0;
        for (int k = 1; k < RC; k++) begin
            cyc();
            chk("col_next_quiet", {31'd0, o_valid}, 32'h0);
        end
        cyc();
        chk("col_next_fire", frame(), fexp(1, 0, 0, 16'h0007));

        // reset mid-SEND drops the frame at once
        rst_n = 1'b0;
        #1;
        chk("rst_send_frame", frame(), fexp(0, 0, 0, 16'h0000));
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 3 * RC + 2; k++) begin
            cyc();
            chk("rst_no_refresh", {31'd0, o_valid}, 32'h0);
        end
        chk("rst_end_rdy", {30'd0, o_res_ready, o_ech_ready}, 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
